ysyx_24100029_pipe_stage: RTL
=============================

# ysyx_24100029_pipe_stage

Parametrised pipeline stage register with valid/ready handshake, optional two-entry skid buffer and synchronous flush. It is the generalised successor of the plain enabled flop. It sits between NPC pipeline stages (IFU→IDU→EXU→LSU→WBU) and carries each stage's payload bundle. The stage provides backpressure and cuts the ready path without losing throughput.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- RESET_VAL, 0, value loaded into every data register on reset
- SKID, 1, 1 = two-entry skid mode (registered in_ready); 0 = single-entry mode (combinational in_ready)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- flush  in  1  discard all held entries at the next edge
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept payload this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  stage holds a valid payload
- out_ready  in  1  downstream accepts payload this cycle
- out_data  out  WIDTH  payload presented downstream

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage:
  - main entry (main_valid, main_data) drives out_valid/out_data directly.
  - skid entry (skid_valid, skid_data) exists only when SKID=1.
- SKID=1 states: EMPTY (neither entry valid), BUSY (main only), FULL (main and skid).
  - in_ready = !skid_valid (pure register output).
  - EMPTY: in_valid → BUSY, main<=in_data.
  - BUSY, in_fire & out_fire: stay BUSY, main<=in_data.
  - BUSY, in_fire & !out_ready: → FULL, skid<=in_data, main held.
  - BUSY, !in_fire & out_fire: → EMPTY.
  - FULL (in_ready=0): out_ready → BUSY, main<=skid_data; otherwise hold both entries.
- SKID=0: no skid entry, no FULL state.
  - in_ready = !main_valid | out_ready.
  - in_fire loads main; out_fire & !in_fire clears main_valid.
- Holding rules:
  - Payload order is strictly FIFO.
  - While out_valid=1 & out_ready=0, out_data and out_valid stay stable.
  - Data registers load only on a fire; they hold otherwise, including garbage when invalid.
- Flush:
  - At the edge, main_valid and skid_valid clear, giving EMPTY.
  - A transfer on either side in the flush cycle counts as complete to its partner, but its payload is dropped.
  - Flush beats in_fire.
  - Data registers are not forced to RESET_VAL.
- Reset: main_valid = skid_valid = 0, data registers = RESET_VAL; reset beats flush.
- Simultaneous in_fire & out_fire in FULL cannot occur, because in_ready=0 there.

## Timing
- Reset values:
  - out_valid=0, out_data=RESET_VAL.
  - in_ready=1 (SKID=1); in_ready=1 (SKID=0, since main empty).
- Latency: 1 cycle, in_fire at edge N gives out_valid at N+1.
- Throughput: 1 payload/cycle sustained with out_ready held high, in both modes.
- Stall recovery, SKID=1:
  - The payload accepted in the stall cycle lands in skid.
  - in_ready drops the cycle after.
  - in_ready rises again the cycle after out_ready returns.
- Combinational paths:
  - SKID=1: none from out_ready to in_ready; all outputs are registered.
  - SKID=0: out_ready → in_ready is combinational.
- No path from in_data to out_data without a register.

## Structure
- Shared package ysyx_24100029_pkg holds:
  - state encoding localparams ST_EMPTY, ST_BUSY, ST_FULL (2 bits);
  - the default payload width constant used by stage bundles.
- Data and valid flops are instances of ysyx_24100029_Reg with WIDTH/RESET_VAL passed through; wen = the load condition.
- Skid entry is built under generate when SKID=1.
- The state is implied by (main_valid, skid_valid); no separate state register.

## Test plan
- Reset, WIDTH=32, RESET_VAL=0xDEADBEEF → out_valid=0, out_data=0xDEADBEEF, in_ready=1.
- Stream 0x1..0x8 back-to-back, out_ready=1 → outputs 0x1..0x8 on consecutive cycles starting one cycle after first in_fire.
- SKID=1 backpressure:
  - send 0xA, 0xB, 0xC; out_ready=0 from cycle 1.
  - Required: FULL with main=0xA, skid=0xB; in_ready=0; 0xC held upstream.
  - Release: outputs 0xA, 0xB, 0xC in order, no loss or duplicate.
- SKID=0, out_ready=0 with main full → in_ready=0 same cycle; raising out_ready → in_ready=1 same cycle.
- Flush while FULL, in_valid=1 → next cycle out_valid=0, in_ready=1; next payload 0x55 emerges normally.
- Random valid/ready toggling against a reference queue model, 10k cycles, both SKID values → order and count match; out_data stable while stalled.

Source files
------------

// File: rtl/ysyx_24100029_pkg.sv
// Shared definitions for the NPC pipeline stage bundles.
//   ST_EMPTY/ST_BUSY/ST_FULL : stage occupancy encoded as {skid_valid, main_valid}
//   PAYLOAD_WIDTH            : default payload width carried between stages
package ysyx_24100029_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam int unsigned PAYLOAD_WIDTH = 32;

endpackage

// File: rtl/ysyx_24100029_Reg.sv
// Generic enabled register with synchronous active-high reset.
//   clock : rising-edge clock
//   reset : synchronous reset, loads RESET_VAL
//   din   : next value, captured when wen is high
//   dout  : registered value
//   wen   : write enable
module ysyx_24100029_Reg #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_24100029_pipe_stage.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer and synchronous flush.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   flush               : drop all held entries at the next edge
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
// SKID=1 registers in_ready (no out_ready->in_ready path); SKID=0 keeps a single
// entry and in_ready depends combinationally on out_ready.
module ysyx_24100029_pipe_stage
  import ysyx_24100029_pkg::*;
#(
  parameter int unsigned      WIDTH     = PAYLOAD_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      SKID      = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid;
  logic             main_valid_d;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] main_din;
  logic             main_wen;

  ysyx_24100029_Reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main_data (
    .clock (clock),
    .reset (reset),
    .din   (main_din),
    .dout  (main_data),
    .wen   (main_wen)
  );

  ysyx_24100029_Reg #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_main_valid (
    .clock (clock),
    .reset (reset),
    .din   (main_valid_d),
    .dout  (main_valid),
    .wen   (1'b1)
  );

  assign out_valid = main_valid;
  assign out_data  = main_data;

  if (SKID != 0) begin : gen_skid
    logic             skid_valid;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data;
    logic             skid_wen;
    logic [1:0]       state;

    ysyx_24100029_Reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_skid_data (
      .clock (clock),
      .reset (reset),
      .din   (in_data),
      .dout  (skid_data),
      .wen   (skid_wen)
    );

    ysyx_24100029_Reg #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
    ) u_skid_valid (
      .clock (clock),
      .reset (reset),
      .din   (skid_valid_d),
      .dout  (skid_valid),
      .wen   (1'b1)
    );

    assign in_ready = ~skid_valid;
    assign state    = {skid_valid, main_valid};

    // in_ready is 1 in EMPTY and BUSY, so in_valid alone means in_fire there.
    always_comb begin
      main_wen     = 1'b0;
      main_din     = in_data;
      main_valid_d = main_valid;
      skid_wen     = 1'b0;
      skid_valid_d = skid_valid;
      case (state)
        ST_EMPTY: begin
          main_wen     = in_valid;
          main_valid_d = in_valid;
        end
        ST_BUSY: begin
          if (in_valid && out_ready) begin
            main_wen = 1'b1;
          end else if (in_valid) begin
            skid_wen     = 1'b1;
            skid_valid_d = 1'b1;
          end else if (out_ready) begin
            main_valid_d = 1'b0;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            main_wen     = 1'b1;
            main_din     = skid_data;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // skid without main is unreachable; recover to EMPTY
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
      if (flush) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    end
  end else begin : gen_single
    logic in_fire;

    assign in_ready     = ~main_valid | out_ready;
    assign in_fire      = in_valid & in_ready;
    assign main_wen     = in_fire;
    assign main_din     = in_data;
    assign main_valid_d = ~flush & (in_fire | (main_valid & ~out_ready));
  end

endmodule
